morph_ctrl: RTL and testbench

Frame/line sequencer and configuration controller for the binary morphology stage (3x3 erode/dilate) in the OV5640-to-LCD image path. Tracks frame and pixel position from the incoming threshold-stage syncs, gates the morphology line buffers, marks which pixels carry a fully populated 3x3 window, and applies a frame-synchronous operation mode. Sits between the threshold block and the morphology datapath; the datapath consumes `lb_clken`, `win_valid` and `op_mode`.

---
 rtl/morph_pkg.sv | 24 ++
 rtl/morph_ctrl_if.sv | 20 ++
 rtl/sync_edge_det.sv | 28 ++
 rtl/morph_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_morph_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/morph_pkg.sv
// Shared definitions for the binary morphology control path: mode
// encodings, sequencer states and default frame geometry.
package morph_pkg;

    localparam logic [1:0] MORPH_BYPASS = 2'b00;
    localparam logic [1:0] MORPH_ERODE  = 2'b01;
    localparam logic [1:0] MORPH_DILATE = 2'b10;

    localparam int MORPH_H_ACTIVE_DEF = 480;
    localparam int MORPH_V_ACTIVE_DEF = 272;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DE = 2'd1,
        ACTIVE  = 2'd2,
        HBLANK  = 2'd3
    } morph_state_e;

    // The reserved encoding 11 runs the datapath as bypass.
    function automatic logic [1:0] morph_sanitize_mode(input logic [1:0] mode);
        return (mode == MORPH_ERODE || mode == MORPH_DILATE) ? mode : MORPH_BYPASS;
    endfunction

endpackage

// File: rtl/morph_ctrl_if.sv
// Sync/stream-side bundle between the threshold stage, morph_ctrl and the
// morphology datapath. master = sync source, slave = morph_ctrl.
interface morph_ctrl_if;
    logic       in_vs;
    logic       in_hs;
    logic       in_de;
    logic [1:0] op_mode;
    logic       lb_clken;
    logic       win_valid;

    modport master (
        output in_vs, in_hs, in_de,
        input  op_mode, lb_clken, win_valid
    );

    modport slave (
        input  in_vs, in_hs, in_de,
        output op_mode, lb_clken, win_valid
    );
endinterface

// File: rtl/sync_edge_det.sv
// Edge detector for a sync input: normalises polarity, keeps one cycle of
// registered history and reports assertion/deassertion edges combinationally
// against that history.
module sync_edge_det #(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);
    logic prev_reg;

    assign level = (sig == POL);
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

    // One-cycle history of the normalised level; starts inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level;
        end
    end
endmodule

// File: rtl/morph_ctrl.sv
// Frame/line sequencer for the 3x3 morphology stage. Tracks pixel position
// from in_vs/in_de, gates the line buffers, flags full 3x3 windows and
// commits the requested mode at each frame start.
// Optional: define MORPH_CTRL_STATS_EN to add 16-bit saturating counters
// stat_frames, stat_line_errs and stat_frame_errs.
module morph_ctrl
    import morph_pkg::*;
#(
    parameter int H_ACTIVE = MORPH_H_ACTIVE_DEF,
    parameter int V_ACTIVE = MORPH_V_ACTIVE_DEF,
    parameter int CNT_W    = 11,
    parameter bit VS_POL   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    morph_ctrl_if.slave      bus,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_wr,
    output logic [CNT_W-1:0] col_cnt,
    output logic [CNT_W-1:0] row_cnt,
    output logic             frame_start,
    output logic             frame_done,
    output logic             line_err,
    output logic             frame_err
`ifdef MORPH_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_line_errs,
    output logic [15:0]      stat_frame_errs
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LINES = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(2);

    morph_state_e     state_reg;
    logic [CNT_W-1:0] col_cnt_reg;
    logic [CNT_W-1:0] row_cnt_reg;
    logic [1:0]       pending_reg;
    logic [1:0]       op_mode_reg;
    logic             win_valid_reg;
    logic             frame_start_reg;
    logic             frame_done_reg;
    logic             line_err_reg;
    logic             frame_err_reg;

    logic             vs_level, vs_rise, vs_fall;
    logic             de_level, de_rise, de_fall;

    sync_edge_det #(.POL(VS_POL)) u_vs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (bus.in_vs),
        .level (vs_level),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    sync_edge_det #(.POL(1'b1)) u_de_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (bus.in_de),
        .level (de_level),
        .rise  (de_rise),
        .fall  (de_fall)
    );

    // Lines are delimited by in_de alone; hsync and the vs level are not needed.
    logic unused_sync;
    assign unused_sync = ^{bus.in_hs, vs_level, vs_fall};

    logic             in_frame;
    logic             first_pix;
    logic [CNT_W-1:0] col_pos;
    logic [CNT_W-1:0] row_inc;
    logic [CNT_W-1:0] row_at_vs;
    logic             win_next;

    // Position of the pixel sampled this cycle and the saturating row step.
    always_comb begin
        in_frame  = (state_reg != IDLE);
        first_pix = (state_reg == WAIT_DE) || (state_reg == HBLANK);
        if (first_pix) begin
            col_pos = '0;
        end else if (col_cnt_reg == CNT_MAX) begin
            col_pos = CNT_MAX;
        end else begin
            col_pos = col_cnt_reg + CNT_W'(1);
        end
        row_inc   = (row_cnt_reg == CNT_MAX) ? CNT_MAX : row_cnt_reg + CNT_W'(1);
        // A line that ends in the same cycle as the vs edge still counts.
        row_at_vs = (state_reg == ACTIVE && de_fall) ? row_inc : row_cnt_reg;
        win_next  = (col_pos >= WIN_MIN) && (row_cnt_reg >= WIN_MIN);
    end

    // Sequencer FSM with all registered outputs and the mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            col_cnt_reg     <= '0;
            row_cnt_reg     <= '0;
            pending_reg     <= MORPH_BYPASS;
            op_mode_reg     <= MORPH_BYPASS;
            win_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            line_err_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            win_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            line_err_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;

            // The commit below reads the old pending value, so a write in the
            // vs-edge cycle lands one frame later.
            if (cfg_wr) begin
                pending_reg <= cfg_mode;
            end

            if (vs_rise) begin
                if (state_reg == ACTIVE || state_reg == HBLANK) begin
                    frame_done_reg <= 1'b1;
                    frame_err_reg  <= (row_at_vs != V_LINES);
                end
                frame_start_reg <= 1'b1;
                op_mode_reg     <= morph_sanitize_mode(pending_reg);
                col_cnt_reg     <= '0;
                row_cnt_reg     <= '0;
                state_reg       <= WAIT_DE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= IDLE;
                    end
                    WAIT_DE: begin
                        if (de_level) begin
                            state_reg     <= ACTIVE;
                            col_cnt_reg   <= col_pos;
                            win_valid_reg <= win_next;
                        end
                    end
                    ACTIVE: begin
                        if (de_level) begin
                            col_cnt_reg   <= col_pos;
                            win_valid_reg <= win_next;
                        end else if (de_fall) begin
                            state_reg    <= HBLANK;
                            line_err_reg <= (col_cnt_reg != H_LAST);
                            col_cnt_reg  <= '0;
                            row_cnt_reg  <= row_inc;
                        end
                    end
                    HBLANK: begin
                        if (de_rise) begin
                            state_reg     <= ACTIVE;
                            col_cnt_reg   <= col_pos;
                            win_valid_reg <= win_next;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.lb_clken  = de_level & in_frame;
    assign bus.win_valid = win_valid_reg;
    assign bus.op_mode   = op_mode_reg;
    assign col_cnt       = col_cnt_reg;
    assign row_cnt       = row_cnt_reg;
    assign frame_start   = frame_start_reg;
    assign frame_done    = frame_done_reg;
    assign line_err      = line_err_reg;
    assign frame_err     = frame_err_reg;

`ifdef MORPH_CTRL_STATS_EN
    logic [2:0] stat_evt;
    assign stat_evt = {frame_err_reg, line_err_reg, frame_done_reg};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        // Saturating event counter, one per statistic.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (stat_evt[gi] && cnt_reg != 16'hFFFF) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign stat_frames     = g_stat[0].cnt_reg;
    assign stat_line_errs  = g_stat[1].cnt_reg;
    assign stat_frame_errs = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_morph_ctrl.sv
// Directed bench for morph_ctrl on a reduced 6x5 frame geometry.
module tb_morph_ctrl;
    import morph_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic        cfg_wr;
    logic [10:0] col_cnt;
    logic [10:0] row_cnt;
    logic        frame_start, frame_done, line_err, frame_err;
`ifdef MORPH_CTRL_STATS_EN
    logic [15:0] stat_frames, stat_line_errs, stat_frame_errs;
`endif

    int tests = 0;
    int fails = 0;

    // Monitor state, written only by the monitor process.
    int          fs_cnt = 0, fd_cnt = 0, fe_cnt = 0, le_cnt = 0;
    int          win_frame = 0, lerr_frame = 0;
    logic        first_seen = 1'b0;
    logic [10:0] first_col = '0, first_row = '0;

    always #5 clk = ~clk;

    morph_ctrl_if bus ();

    morph_ctrl #(
        .H_ACTIVE (6),
        .V_ACTIVE (5),
        .CNT_W    (11),
        .VS_POL   (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .cfg_mode    (cfg_mode),
        .cfg_wr      (cfg_wr),
        .col_cnt     (col_cnt),
        .row_cnt     (row_cnt),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .frame_err   (frame_err)
`ifdef MORPH_CTRL_STATS_EN
        ,
        .stat_frames     (stat_frames),
        .stat_line_errs  (stat_line_errs),
        .stat_frame_errs (stat_frame_errs)
`endif
    );

    // Pulse and window bookkeeping, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_start) fs_cnt <= fs_cnt + 1;
        if (frame_done)  fd_cnt <= fd_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
        if (line_err)    le_cnt <= le_cnt + 1;
        if (frame_start) begin
            win_frame  <= 0;
            lerr_frame <= 0;
            first_seen <= 1'b0;
        end else begin
            if (bus.win_valid) begin
                win_frame <= win_frame + 1;
                if (!first_seen) begin
                    first_seen <= 1'b1;
                    first_col  <= col_cnt;
                    first_row  <= row_cnt;
                end
            end
            if (line_err) lerr_frame <= lerr_frame + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // One cycle: apply inputs, pass the sampling edge, settle 1 ns.
    task automatic drive(input logic vs, input logic de);
        bus.in_vs = vs;
        bus.in_de = de;
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int len);
        for (int i = 0; i < len; i++) drive(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    endtask

    task automatic send_lines(input int n);
        for (int i = 0; i < n; i++) send_line(6);
    endtask

    task automatic vs_edge();
        drive(1'b1, 1'b0);
        $display("[TB] vs edge t=%0t op_mode=%0d frame_start=%0b frame_done=%0b frame_err=%0b",
                 $time, bus.op_mode, frame_start, frame_done, frame_err);
    endtask

    task automatic vs_tail();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_mode = 2'b00;
        cfg_wr = 1'b0;
        bus.in_hs = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        tests++;
        if (bus.op_mode !== 2'b00) begin
            fails++; $display("FAIL reset_op_mode: got %0d expected 0", bus.op_mode);
        end
        tests++;
        if ({bus.lb_clken, bus.win_valid} !== 2'b00) begin
            fails++; $display("FAIL reset_lb_win: got %b expected 00", {bus.lb_clken, bus.win_valid});
        end
        tests++;
        if ({col_cnt, row_cnt} !== 22'd0) begin
            fails++; $display("FAIL reset_counters: got col=%0d row=%0d expected 0/0", col_cnt, row_cnt);
        end
        tests++;
        if ({frame_start, frame_done, line_err, frame_err} !== 4'b0000) begin
            fails++; $display("FAIL reset_pulses: got %b expected 0000",
                              {frame_start, frame_done, line_err, frame_err});
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b1);
        tests++;
        if (bus.lb_clken !== 1'b0) begin
            fails++; $display("FAIL idle_lb_clken: got %b expected 0", bus.lb_clken);
        end
        drive(1'b0, 1'b1);
        tests++;
        if (col_cnt !== 11'd0) begin
            fails++; $display("FAIL idle_col_cnt: got %0d expected 0", col_cnt);
        end
        drive(1'b0, 1'b0);
        $display("[TB] reset sequence done");
    endtask

    task automatic test_mode_commit();
        int fs0, fd0, fe0, le0;
        cfg_mode = 2'b01;
        cfg_wr = 1'b1;
        drive(1'b0, 1'b0);
        cfg_wr = 1'b0;
        tests++;
        if (bus.op_mode !== 2'b00) begin
            fails++; $display("FAIL pending_not_committed: got %0d expected 0", bus.op_mode);
        end
        fs0 = fs_cnt; fd0 = fd_cnt; fe0 = fe_cnt; le0 = le_cnt;
        vs_edge();
        tests++;
        if (frame_start !== 1'b1 || frame_done !== 1'b0) begin
            fails++; $display("FAIL first_vs_pulses: got start=%b done=%b expected 1/0", frame_start, frame_done);
        end
        tests++;
        if (bus.op_mode !== 2'b01) begin
            fails++; $display("FAIL commit_op_mode: got %0d expected 1", bus.op_mode);
        end
        drive(1'b1, 1'b0);
        tests++;
        if (frame_start !== 1'b0) begin
            fails++; $display("FAIL frame_start_width: got %b expected 0", frame_start);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        tests++;
        if (bus.lb_clken !== 1'b1) begin
            fails++; $display("FAIL lb_clken_active: got %b expected 1", bus.lb_clken);
        end
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        tests++;
        if (col_cnt !== 11'd2 || row_cnt !== 11'd0 || bus.win_valid !== 1'b0) begin
            fails++; $display("FAIL third_pixel: got col=%0d row=%0d win=%b expected 2/0/0",
                              col_cnt, row_cnt, bus.win_valid);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        tests++;
        if (line_err !== 1'b0 || row_cnt !== 11'd1 || col_cnt !== 11'd0) begin
            fails++; $display("FAIL line0_end: got lerr=%b row=%0d col=%0d expected 0/1/0",
                              line_err, row_cnt, col_cnt);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        send_lines(4);
        tests++;
        if (row_cnt !== 11'd5) begin
            fails++; $display("FAIL full_frame_rows: got %0d expected 5", row_cnt);
        end
        tests++;
        if (win_frame !== 12) begin
            fails++; $display("FAIL win_valid_count: got %0d expected 12", win_frame);
        end
        tests++;
        if (first_col !== 11'd2 || first_row !== 11'd2) begin
            fails++; $display("FAIL first_window: got col=%0d row=%0d expected 2/2", first_col, first_row);
        end
        vs_edge();
        tests++;
        if (frame_done !== 1'b1 || frame_err !== 1'b0 || frame_start !== 1'b1) begin
            fails++; $display("FAIL frame_end_pulses: got done=%b err=%b start=%b expected 1/0/1",
                              frame_done, frame_err, frame_start);
        end
        vs_tail();
        tests++;
        if (fs_cnt - fs0 !== 2 || fd_cnt - fd0 !== 1 || fe_cnt !== fe0 || le_cnt !== le0) begin
            fails++; $display("FAIL pulse_counts: got fs=%0d fd=%0d fe=%0d le=%0d expected 2/1/0/0",
                              fs_cnt - fs0, fd_cnt - fd0, fe_cnt - fe0, le_cnt - le0);
        end
    endtask

    task automatic test_line_err();
        send_lines(2);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        tests++;
        if (line_err !== 1'b1 || row_cnt !== 11'd3) begin
            fails++; $display("FAIL short_line_err: got lerr=%b row=%0d expected 1/3", line_err, row_cnt);
        end
        drive(1'b0, 1'b0);
        tests++;
        if (line_err !== 1'b0) begin
            fails++; $display("FAIL line_err_width: got %b expected 0", line_err);
        end
        drive(1'b0, 1'b0);
        send_lines(2);
        tests++;
        if (row_cnt !== 11'd5 || lerr_frame !== 1) begin
            fails++; $display("FAIL short_line_rows: got row=%0d lerrs=%0d expected 5/1", row_cnt, lerr_frame);
        end
        vs_edge();
        tests++;
        if (frame_done !== 1'b1 || frame_err !== 1'b0) begin
            fails++; $display("FAIL short_line_frame: got done=%b err=%b expected 1/0", frame_done, frame_err);
        end
        vs_tail();
    endtask

    task automatic test_frame_err();
        send_lines(4);
        tests++;
        if (row_cnt !== 11'd4) begin
            fails++; $display("FAIL short_frame_rows: got %0d expected 4", row_cnt);
        end
        vs_edge();
        tests++;
        if (frame_done !== 1'b1 || frame_err !== 1'b1) begin
            fails++; $display("FAIL short_frame_err: got done=%b err=%b expected 1/1", frame_done, frame_err);
        end
        drive(1'b1, 1'b0);
        tests++;
        if (frame_err !== 1'b0) begin
            fails++; $display("FAIL frame_err_width: got %b expected 0", frame_err);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic test_cfg_same_cycle();
        send_lines(5);
        cfg_mode = 2'b10;
        cfg_wr = 1'b1;
        vs_edge();
        cfg_wr = 1'b0;
        tests++;
        if (bus.op_mode !== 2'b01 || frame_err !== 1'b0) begin
            fails++; $display("FAIL same_cycle_keep: got mode=%0d err=%b expected 1/0", bus.op_mode, frame_err);
        end
        vs_tail();
        send_lines(5);
        tests++;
        if (bus.op_mode !== 2'b01) begin
            fails++; $display("FAIL mode_stable: got %0d expected 1", bus.op_mode);
        end
        vs_edge();
        tests++;
        if (bus.op_mode !== 2'b10) begin
            fails++; $display("FAIL same_cycle_next: got %0d expected 2", bus.op_mode);
        end
        vs_tail();
        cfg_mode = 2'b11;
        cfg_wr = 1'b1;
        drive(1'b0, 1'b0);
        cfg_wr = 1'b0;
        send_lines(5);
        vs_edge();
        tests++;
        if (bus.op_mode !== 2'b00) begin
            fails++; $display("FAIL reserved_mode: got %0d expected 0", bus.op_mode);
        end
        vs_tail();
    endtask

    task automatic test_reset_mid();
        int lb_hi, win_hi;
        cfg_mode = 2'b10;
        cfg_wr = 1'b1;
        drive(1'b0, 1'b0);
        cfg_wr = 1'b0;
        send_lines(5);
        vs_edge();
        vs_tail();
        send_lines(2);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        tests++;
        if (col_cnt !== 11'd2 || row_cnt !== 11'd2 || bus.win_valid !== 1'b1 || bus.op_mode !== 2'b10) begin
            fails++; $display("FAIL pre_reset_state: got col=%0d row=%0d win=%b mode=%0d expected 2/2/1/2",
                              col_cnt, row_cnt, bus.win_valid, bus.op_mode);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.op_mode !== 2'b00 || bus.lb_clken !== 1'b0 || bus.win_valid !== 1'b0) begin
            fails++; $display("FAIL mid_reset_outputs: got mode=%0d lb=%b win=%b expected 0/0/0",
                              bus.op_mode, bus.lb_clken, bus.win_valid);
        end
        tests++;
        if (col_cnt !== 11'd0 || row_cnt !== 11'd0) begin
            fails++; $display("FAIL mid_reset_counters: got col=%0d row=%0d expected 0/0", col_cnt, row_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lb_hi = 0;
        win_hi = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            if (bus.lb_clken) lb_hi++;
            if (bus.win_valid) win_hi++;
        end
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
            for (int i = 0; i < 6; i++) begin
                drive(1'b0, 1'b1);
                if (bus.lb_clken) lb_hi++;
                if (bus.win_valid) win_hi++;
            end
        end
        drive(1'b0, 1'b0);
        tests++;
        if (lb_hi !== 0 || win_hi !== 0) begin
            fails++; $display("FAIL post_reset_gating: got lb_cycles=%0d win_cycles=%0d expected 0/0", lb_hi, win_hi);
        end
        vs_edge();
        tests++;
        if (frame_start !== 1'b1 || frame_done !== 1'b0 || bus.op_mode !== 2'b00) begin
            fails++; $display("FAIL resume_vs: got start=%b done=%b mode=%0d expected 1/0/0",
                              frame_start, frame_done, bus.op_mode);
        end
        vs_tail();
        drive(1'b0, 1'b1);
        tests++;
        if (bus.lb_clken !== 1'b1 || col_cnt !== 11'd0) begin
            fails++; $display("FAIL resume_lb_clken: got lb=%b col=%0d expected 1/0", bus.lb_clken, col_cnt);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    initial begin
        bus.in_vs = 1'b0;
        bus.in_hs = 1'b0;
        bus.in_de = 1'b0;
        test_reset();
        test_mode_commit();
        test_line_err();
        test_frame_err();
        test_cfg_same_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
